// File: rtl/bit_serial_pkg.sv
// Shared types for the bit-serial datapath core: opcodes, FSM states and
// the carry seed used for subtraction.
package bit_serial_pkg;

    typedef enum logic [2:0] {
        NOP   = 3'b000,
        LOAD  = 3'b001,
        ADD   = 3'b010,
        SUB   = 3'b011,
        STORE = 3'b100,
        MOVA  = 3'b101,
        CLR   = 3'b110,
        RSVD  = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Two's-complement subtract: acc + ~rd + 1, the +1 comes in as carry.
    localparam logic CARRY_INIT_SUB = 1'b1;

endpackage

// File: rtl/bs_shift_reg.sv
// One WIDTH-bit serial register. Shift takes a new bit into the MSB and
// drops the LSB; rotate feeds the LSB back into the MSB so the contents
// return to their original value after WIDTH rotations. Shift wins.
module bs_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift,
    input  logic             rotate,
    input  logic             sin,
    output logic             lsb,
    output logic [WIDTH-1:0] q
);

    // Register update: clear on reset, else shift or rotate right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (shift)
            q <= {sin, q[WIDTH-1:1]};
        else if (rotate)
            q <= {q[0], q[WIDTH-1:1]};
    end

    assign lsb = q[0];

endmodule

// File: rtl/bit_serial_core.sv
// Bit-serial datapath core: NREGS general registers plus an accumulator,
// one full adder processing operands LSB-first over WIDTH cycles.
// Optional feature macro: BIT_SERIAL_FLAGS_EN builds the carry/overflow
// flag registers; without it o_carry and o_ovf are tied low.
module bit_serial_core
    import bit_serial_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 4,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [AW+2:0]    i_instr,
    input  logic [WIDTH-1:0] i_data_switch,
    input  logic             i_start,
    input  logic [AW-1:0]    i_view_sel,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_con_pcincr,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_view,
    output logic             o_carry,
    output logic             o_ovf
);

    localparam int CW = $clog2(WIDTH);

    state_t                      state, state_nx;
    opcode_t                     op_q;
    logic [AW-1:0]               rd_q;
    logic [WIDTH-1:0]            sw_q;
    logic [CW-1:0]               cnt;
    logic                        c_ff;

    opcode_t                     op_in;
    logic                        rd_ok, op_real, accept, last;

    logic [NREGS-1:0]            reg_shift, reg_rot, reg_lsb;
    logic [NREGS-1:0][WIDTH-1:0] reg_q;
    logic                        reg_sin;
    logic                        acc_shift, acc_rot, acc_sin, acc_lsb;
    logic [WIDTH-1:0]            acc_q;
    logic                        rd_bit, b_bit, sum, cout;

    assign op_in   = opcode_t'(i_instr[AW+2:AW]);
    assign rd_ok   = int'(i_instr[AW-1:0]) < NREGS;
    assign op_real = !(op_in inside {NOP, RSVD});
    assign accept  = (state == IDLE) && i_start;
    assign last    = (cnt == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state and handshake outputs; no-op requests go straight to DONE.
    always_comb begin
        state_nx = state;
        o_busy   = 1'b0;
        o_done   = 1'b0;
        case (state)
            IDLE:  if (i_start) state_nx = (op_real && rd_ok) ? SHIFT : DONE;
            SHIFT: begin
                o_busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                o_busy   = 1'b1;
                o_done   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign o_con_pcincr = o_done;

    // Latch the instruction at accept, then run the bit counter and carry.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            op_q <= NOP;
            rd_q <= '0;
            sw_q <= '0;
            cnt  <= '0;
            c_ff <= 1'b0;
        end else if (accept) begin
            op_q <= op_in;
            rd_q <= i_instr[AW-1:0];
            sw_q <= i_data_switch;
            cnt  <= '0;
            c_ff <= (op_in == SUB) ? CARRY_INIT_SUB : 1'b0;
        end else if (state == SHIFT) begin
            cnt  <= last ? '0 : cnt + CW'(1);
            c_ff <= cout;
        end
    end

    // Serial full adder; b is inverted for subtraction.
    assign rd_bit = reg_lsb[rd_q];
    assign b_bit  = rd_bit ^ (op_q == SUB);
    assign sum    = acc_lsb ^ b_bit ^ c_ff;
    assign cout   = (acc_lsb & b_bit) | (acc_lsb & c_ff) | (b_bit & c_ff);

    // Per-cycle routing: the destination shifts, a source register rotates.
    always_comb begin
        reg_shift = '0;
        reg_rot   = '0;
        acc_shift = 1'b0;
        acc_rot   = 1'b0;
        acc_sin   = 1'b0;
        reg_sin   = (op_q == LOAD) ? sw_q[cnt] : acc_lsb;
        if (state == SHIFT) begin
            case (op_q)
                LOAD:  reg_shift[rd_q] = 1'b1;
                ADD, SUB: begin
                    acc_shift     = 1'b1;
                    acc_sin       = sum;
                    reg_rot[rd_q] = 1'b1;
                end
                STORE: begin
                    reg_shift[rd_q] = 1'b1;
                    acc_rot         = 1'b1;
                end
                MOVA: begin
                    acc_shift     = 1'b1;
                    acc_sin       = rd_bit;
                    reg_rot[rd_q] = 1'b1;
                end
                CLR:   acc_shift = 1'b1;
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_reg
        bs_shift_reg #(.WIDTH(WIDTH)) u_reg (
            .clk    (i_clk),
            .rst_n  (i_rst),
            .shift  (reg_shift[g]),
            .rotate (reg_rot[g]),
            .sin    (reg_sin),
            .lsb    (reg_lsb[g]),
            .q      (reg_q[g])
        );
    end

    bs_shift_reg #(.WIDTH(WIDTH)) u_acc (
        .clk    (i_clk),
        .rst_n  (i_rst),
        .shift  (acc_shift),
        .rotate (acc_rot),
        .sin    (acc_sin),
        .lsb    (acc_lsb),
        .q      (acc_q)
    );

    assign o_acc = acc_q;

    // Register view port; out-of-range selects read as zero.
    always_comb begin
        o_view = '0;
        if (int'(i_view_sel) < NREGS) o_view = reg_q[i_view_sel];
    end

`ifdef BIT_SERIAL_FLAGS_EN
    logic carry_flag, ovf_flag;

    // Flags capture on the final ADD/SUB bit; CLR clears them.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            carry_flag <= 1'b0;
            ovf_flag   <= 1'b0;
        end else if (state == SHIFT && last) begin
            if (op_q inside {ADD, SUB}) begin
                carry_flag <= cout;
                ovf_flag   <= c_ff ^ cout;
            end else if (op_q == CLR) begin
                carry_flag <= 1'b0;
                ovf_flag   <= 1'b0;
            end
        end
    end

    assign o_carry = carry_flag;
    assign o_ovf   = ovf_flag;
`else
    assign o_carry = 1'b0;
    assign o_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_bit_serial_core.sv
// Directed bench for bit_serial_core: an 8-bit/4-register instance driven
// from a vector table, plus a 16-bit/5-register instance for the
// out-of-range register cases.
module tb_bit_serial_core;

`ifdef BIT_SERIAL_FLAGS_EN
    localparam bit F = 1'b1;
`else
    localparam bit F = 1'b0;
`endif

    logic        clk, rst_n;
    logic [4:0]  a_instr;
    logic [7:0]  a_sw;
    logic        a_start;
    logic [1:0]  a_vsel;
    logic        a_busy, a_done, a_pc, a_carry, a_ovf;
    logic [7:0]  a_acc, a_view;

    logic [5:0]  b_instr;
    logic [15:0] b_sw;
    logic        b_start;
    logic [2:0]  b_vsel;
    logic        b_busy, b_done, b_pc, b_carry, b_ovf;
    logic [15:0] b_acc, b_view;

    int n_chk = 0;
    int n_err = 0;
    int cur   = -1;

    bit_serial_core #(.WIDTH(8), .NREGS(4)) u_dut (
        .i_clk(clk), .i_rst(rst_n), .i_instr(a_instr), .i_data_switch(a_sw),
        .i_start(a_start), .i_view_sel(a_vsel), .o_busy(a_busy), .o_done(a_done),
        .o_con_pcincr(a_pc), .o_acc(a_acc), .o_view(a_view), .o_carry(a_carry),
        .o_ovf(a_ovf)
    );

    bit_serial_core #(.WIDTH(16), .NREGS(5)) u_dut5 (
        .i_clk(clk), .i_rst(rst_n), .i_instr(b_instr), .i_data_switch(b_sw),
        .i_start(b_start), .i_view_sel(b_vsel), .o_busy(b_busy), .o_done(b_done),
        .o_con_pcincr(b_pc), .o_acc(b_acc), .o_view(b_view), .o_carry(b_carry),
        .o_ovf(b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [1:0] rd;
        logic [7:0] sw;
        bit         noise;
        logic [7:0] acc;
        logic [1:0] vsel;
        logic [7:0] view;
        bit         c;
        bit         v;
    } vec_t;

    vec_t vt[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL vec %0d %s: got %0h expected %0h", cur, name, act, exp);
        end
    endtask

    task automatic run_a(input logic [2:0] op, input logic [1:0] rd, input logic [7:0] sw,
                         input bit noise, input int exp_lat);
        int lat;
        @(negedge clk);
        a_instr = {op, rd};
        a_sw    = sw;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        a_instr = ~{op, rd};
        a_sw    = ~sw;
        chk("busy_after_accept", 32'(a_busy), 32'(1));
        lat = 0;
        while (!a_done && lat < 40) begin
            if (noise) begin
                a_start = 1'b1;
                a_instr = {3'b110, 2'd0};
            end
            @(posedge clk); #1;
            a_start = 1'b0;
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("pcincr", 32'(a_pc), 32'(1));
        @(posedge clk); #1;
        chk("done_pulse", 32'(a_done), 32'(0));
        chk("busy_idle", 32'(a_busy), 32'(0));
    endtask

    task automatic run_b(input logic [2:0] op, input logic [2:0] rd, input logic [15:0] sw,
                         input int exp_lat);
        int lat;
        @(negedge clk);
        b_instr = {op, rd};
        b_sw    = sw;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        b_sw    = ~sw;
        lat = 0;
        while (!b_done && lat < 40) begin
            b_start = 1'b1;
            @(posedge clk); #1;
            b_start = 1'b0;
            lat++;
        end
        chk("b_latency", 32'(lat), 32'(exp_lat));
        @(posedge clk); #1;
        chk("b_done_pulse", 32'(b_done), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           op    rd    sw    nz  acc   sel   view  c  v
        vt = '{
            '{3'd1, 2'd2, 8'hA5, 0, 8'h00, 2'd2, 8'hA5, 0, 0},
            '{3'd1, 2'd0, 8'hFF, 0, 8'h00, 2'd0, 8'hFF, 0, 0},
            '{3'd5, 2'd0, 8'h00, 0, 8'hFF, 2'd0, 8'hFF, 0, 0},
            '{3'd1, 2'd1, 8'h01, 0, 8'hFF, 2'd1, 8'h01, 0, 0},
            '{3'd2, 2'd1, 8'h00, 0, 8'h00, 2'd1, 8'h01, 1, 0},
            '{3'd1, 2'd3, 8'h07, 0, 8'h00, 2'd3, 8'h07, 1, 0},
            '{3'd1, 2'd0, 8'h05, 0, 8'h00, 2'd0, 8'h05, 1, 0},
            '{3'd5, 2'd0, 8'h00, 0, 8'h05, 2'd0, 8'h05, 1, 0},
            '{3'd3, 2'd3, 8'h00, 0, 8'hFE, 2'd3, 8'h07, 0, 0},
            '{3'd2, 2'd3, 8'h00, 0, 8'h05, 2'd3, 8'h07, 1, 0},
            '{3'd1, 2'd0, 8'h01, 0, 8'h05, 2'd0, 8'h01, 1, 0},
            '{3'd1, 2'd1, 8'h7F, 0, 8'h05, 2'd1, 8'h7F, 1, 0},
            '{3'd5, 2'd1, 8'h00, 0, 8'h7F, 2'd1, 8'h7F, 1, 0},
            '{3'd2, 2'd0, 8'h00, 0, 8'h80, 2'd0, 8'h01, 0, 1},
            '{3'd4, 2'd2, 8'h00, 0, 8'h80, 2'd2, 8'h80, 0, 1},
            '{3'd6, 2'd0, 8'h00, 0, 8'h00, 2'd2, 8'h80, 0, 0},
            '{3'd0, 2'd0, 8'h00, 0, 8'h00, 2'd1, 8'h7F, 0, 0},
            '{3'd7, 2'd3, 8'h00, 0, 8'h00, 2'd3, 8'h07, 0, 0},
            '{3'd2, 2'd2, 8'h00, 1, 8'h80, 2'd2, 8'h80, 0, 0},
            '{3'd3, 2'd2, 8'h00, 1, 8'h00, 2'd2, 8'h80, 1, 0},
            '{3'd3, 2'd0, 8'h00, 0, 8'hFF, 2'd0, 8'h01, 0, 0},
            '{3'd4, 2'd3, 8'h00, 0, 8'hFF, 2'd3, 8'hFF, 0, 0},
            '{3'd1, 2'd3, 8'h3C, 0, 8'hFF, 2'd3, 8'h3C, 0, 0}
        };

        rst_n   = 1'b0;
        a_instr = '0; a_sw = '0; a_start = 1'b0; a_vsel = '0;
        b_instr = '0; b_sw = '0; b_start = 1'b0; b_vsel = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(a_busy), 32'(0));
        chk("rst_done", 32'(a_done), 32'(0));
        chk("rst_pc", 32'(a_pc), 32'(0));
        chk("rst_acc", 32'(a_acc), 32'(0));
        chk("rst_carry", 32'(a_carry), 32'(0));
        chk("rst_ovf", 32'(a_ovf), 32'(0));
        chk("rst_b_busy", 32'(b_busy), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Build up state (and a carry flag), then abort an ADD mid-shift.
        run_a(3'd1, 2'd0, 8'hFF, 0, 8);
        run_a(3'd5, 2'd0, 8'h00, 0, 8);
        run_a(3'd1, 2'd1, 8'h01, 0, 8);
        run_a(3'd2, 2'd1, 8'h00, 0, 8);
        chk("pre_carry", 32'(a_carry), 32'(F));
        run_a(3'd5, 2'd0, 8'h00, 0, 8);
        chk("pre_acc", 32'(a_acc), 32'h0FF);
        @(negedge clk);
        a_instr = {3'd2, 2'd1};
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_mid", 32'(a_busy), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(a_busy), 32'(0));
        chk("abort_done", 32'(a_done), 32'(0));
        chk("abort_acc", 32'(a_acc), 32'(0));
        chk("abort_carry", 32'(a_carry), 32'(0));
        chk("abort_ovf", 32'(a_ovf), 32'(0));
        for (int i = 0; i < 4; i++) begin
            a_vsel = 2'(i);
            #1;
            chk("abort_view", 32'(a_view), 32'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven sequence from the cleared state.
        for (int i = 0; i < 23; i++) begin
            cur = i;
            run_a(vt[i].op, vt[i].rd, vt[i].sw, vt[i].noise,
                  (vt[i].op == 3'd0 || vt[i].op == 3'd7) ? 0 : 8);
            a_vsel = vt[i].vsel;
            #1;
            chk("acc", 32'(a_acc), 32'(vt[i].acc));
            chk("view", 32'(a_view), 32'(vt[i].view));
            chk("carry", 32'(a_carry), 32'(vt[i].c & F));
            chk("ovf", 32'(a_ovf), 32'(vt[i].v & F));
        end

        // WIDTH=16, NREGS=5: out-of-range rd completes at once with no effect.
        cur = 100;
        run_b(3'd1, 3'd4, 16'hBEEF, 16);
        b_vsel = 3'd4; #1;
        chk("b_view4", 32'(b_view), 32'h0BEEF);
        run_b(3'd1, 3'd5, 16'h1234, 0);
        #1;
        chk("b_view4_hold", 32'(b_view), 32'h0BEEF);
        b_vsel = 3'd5; #1;
        chk("b_view5", 32'(b_view), 32'(0));
        chk("b_acc0", 32'(b_acc), 32'(0));
        run_b(3'd5, 3'd6, 16'h0000, 0);
        chk("b_acc_mova6", 32'(b_acc), 32'(0));
        run_b(3'd0, 3'd0, 16'h0000, 0);
        run_b(3'd5, 3'd4, 16'h0000, 16);
        chk("b_acc_mova4", 32'(b_acc), 32'h0BEEF);
        b_vsel = 3'd7; #1;
        chk("b_view7", 32'(b_view), 32'(0));
        run_b(3'd3, 3'd7, 16'h0000, 0);
        chk("b_acc_sub7", 32'(b_acc), 32'h0BEEF);
        chk("b_carry", 32'(b_carry), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
